// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and width helpers for the uart_tx byte-channel arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  // Index width for a requester vector; never zero so NUM_REQ=1 still has a port.
  function automatic int rr_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  logic [IW-1:0] w_c;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_c   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_c = IW'((int'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_req[w_c]) begin
        o_any      = 1'b1;
        o_gnt[w_c] = 1'b1;
        o_idx      = w_c;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx byte channel among NUM_REQ sources.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]       i_req_last,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic [WIDTH-1:0]         o_tx_dout,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic                     o_busy
);

  localparam int IW = rr_idx_w(NUM_REQ);
  localparam int BW = cnt_w(MAX_BURST);
  localparam int TW = cnt_w(TIMEOUT);
  localparam logic [BW-1:0] BURST_END = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] IDLE_END  = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

  state_t                        r_state, w_state_nxt;
  logic [NUM_REQ-1:0]            r_grant, w_grant_nxt;
  logic [IW-1:0]                 r_sel, w_sel_nxt;
  logic [IW-1:0]                 r_ptr, w_ptr_nxt;
  logic [BW-1:0]                 r_beat_cnt, w_beat_nxt;
  logic [TW-1:0]                 r_idle_cnt, w_idle_nxt;
  logic [NUM_REQ-1:0]            w_pick;
  logic [IW-1:0]                 w_pick_idx;
  logic                          w_any;
  logic [NUM_REQ-1:0][WIDTH-1:0] w_lane_data;
  logic                          w_sel_valid, w_sel_last, w_beat, w_release;

  rr_select #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .i_req (i_req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_pick),
    .o_idx (w_pick_idx),
    .o_any (w_any)
  );

  // One-hot grant doubles as the data mux select, so idle drives zeros.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign w_lane_data[i] = r_grant[i] ? i_req_data[i*WIDTH +: WIDTH] : '0;
  end

  always_comb begin
    o_tx_dout = '0;
    for (int i = 0; i < NUM_REQ; i++) o_tx_dout = o_tx_dout | w_lane_data[i];
  end

  assign w_sel_valid = |(r_grant & i_req_valid);
  assign w_sel_last  = |(r_grant & i_req_last);
  assign o_tx_valid  = w_sel_valid;
  assign o_req_ready = r_grant & {NUM_REQ{i_tx_ready}};
  assign o_grant     = r_grant;
  assign o_busy      = (r_state == S_XFER);
  assign w_beat      = o_tx_valid & i_tx_ready;

  // Backpressure (valid high, ready low) never counts toward the idle timeout.
  assign w_release = (r_state == S_XFER) &
                     ((w_beat & (w_sel_last | (r_beat_cnt == BURST_END))) |
                      (!w_sel_valid & (r_idle_cnt == IDLE_END)));

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_beat_nxt  = r_beat_cnt;
    w_idle_nxt  = r_idle_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_XFER;
          w_grant_nxt = w_pick;
          w_sel_nxt   = w_pick_idx;
          w_beat_nxt  = '0;
          w_idle_nxt  = '0;
        end
      end
      S_XFER: begin
        if (w_beat) begin
          w_beat_nxt = r_beat_cnt + 1'b1;
          w_idle_nxt = '0;
        end else if (!w_sel_valid) begin
          w_idle_nxt = r_idle_cnt + 1'b1;
        end
        if (w_release) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = (r_sel == LAST_IDX) ? '0 : r_sel + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_sel      <= '0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_sel      <= w_sel_nxt;
      r_ptr      <= w_ptr_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_idle_cnt <= w_idle_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: arbitration table, scoreboard of delivered bytes, burst/timeout/backpressure/reset sequences.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   tx_dout;
  logic           tx_valid, tx_ready, busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(16), .TIMEOUT(64)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_tx_dout   (tx_dout),
    .o_tx_valid  (tx_valid),
    .i_tx_ready  (tx_ready),
    .o_grant     (grant),
    .o_busy      (busy)
  );

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
  } exp_t;

  typedef struct packed {
    logic [N-1:0] mask;
    logic [N-1:0] gnt;
  } arb_vec_t;

  exp_t     sb_q[$];
  exp_t     mon_e;
  int       runs_q[$];
  arb_vec_t tbl[10];
  int n_chk = 0, n_pass = 0, n_beats = 0, cur_run = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Every accepted byte must match the oldest expectation, source and value.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      n_beats++;
      cur_run++;
      if (sb_q.size() == 0) check("beat_without_expect", 32'(sb_q.size()), 32'd1);
      else begin
        mon_e = sb_q.pop_front();
        check("beat_src", 32'(oh_idx(grant)), 32'(mon_e.src));
        check("beat_data", 32'(tx_dout), 32'(mon_e.data));
      end
    end
    if (!busy && cur_run != 0) begin
      runs_q.push_back(cur_run);
      cur_run = 0;
    end
  end

  task automatic xfer_byte(input int idx, input logic [7:0] d, input logic lst, output int waits);
    req_valid[idx]       = 1'b1;
    req_data[idx*W +: W] = d;
    req_last[idx]        = lst;
    sb_q.push_back('{src: 2'(idx), data: d});
    waits = 0;
    forever begin
      @(negedge clk);
      if (req_ready[idx]) break;
      waits++;
      if (waits > 300) begin
        check("handshake_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input int idx, input int n, input logic [7:0] base, input logic lst_end);
    int w;
    for (int k = 0; k < n; k++) xfer_byte(idx, base + 8'(k), lst_end && (k == n - 1), w);
    req_valid[idx] = 1'b0;
    req_last[idx]  = 1'b0;
  endtask

  // Several 1-byte packets compete; only the expected winner is queued.
  task automatic arb_round(input logic [N-1:0] mask, input logic [N-1:0] gnt_exp);
    int ei, lat;
    ei = oh_idx(gnt_exp);
    for (int i = 0; i < N; i++) if (mask[i]) begin
      req_valid[i]       = 1'b1;
      req_data[i*W +: W] = 8'h10 + 8'(i);
      req_last[i]        = 1'b1;
    end
    sb_q.push_back('{src: 2'(ei), data: 8'h10 + 8'(ei)});
    lat = 0;
    forever begin
      @(negedge clk);
      if (grant != '0) break;
      lat++;
      if (lat > 20) break;
    end
    check("arb_grant", 32'(grant), 32'(gnt_exp));
    check("arb_latency", 32'(lat), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    req_last  = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    int w, cnt, b0, r0, r1;
    logic stable;
    tbl[0] = '{mask: 4'b0101, gnt: 4'b0100};
    tbl[1] = '{mask: 4'b0011, gnt: 4'b0001};
    tbl[2] = '{mask: 4'b1111, gnt: 4'b0010};
    tbl[3] = '{mask: 4'b1001, gnt: 4'b1000};
    tbl[4] = '{mask: 4'b1110, gnt: 4'b0010};
    tbl[5] = '{mask: 4'b1010, gnt: 4'b1000};
    tbl[6] = '{mask: 4'b0101, gnt: 4'b0001};
    tbl[7] = '{mask: 4'b0100, gnt: 4'b0100};
    tbl[8] = '{mask: 4'b0011, gnt: 4'b0001};
    tbl[9] = '{mask: 4'b1000, gnt: 4'b1000};

    req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    req_valid = '1;
    repeat (2) @(posedge clk); #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // req0 three-byte packet; ptr -> 1
    xfer_byte(0, 8'h41, 1'b0, w); check("b0_first_latency", 32'(w), 32'd1);
    xfer_byte(0, 8'h42, 1'b0, w); check("b0_second_wait", 32'(w), 32'd0);
    xfer_byte(0, 8'h43, 1'b1, w); check("b0_third_wait", 32'(w), 32'd0);
    req_valid[0] = 1'b0; req_last[0] = 1'b0;
    @(negedge clk);
    check("b0_grant_released", 32'(grant), 32'd0);
    check("b0_busy_released", 32'(busy), 32'd0);
    @(posedge clk); #1;

    for (int t = 0; t < 10; t++) arb_round(tbl[t].mask, tbl[t].gnt);

    // ptr=0: req0 and req2 together, one idle cycle between grants
    req_valid[0] = 1'b1; req_data[0*W +: W] = 8'h20; req_last[0] = 1'b1;
    req_valid[2] = 1'b1; req_data[2*W +: W] = 8'h22; req_last[2] = 1'b1;
    sb_q.push_back('{src: 2'd0, data: 8'h20});
    sb_q.push_back('{src: 2'd2, data: 8'h22});
    @(negedge clk); check("pair_wait_idle", 32'(grant), 32'd0);
    @(negedge clk); check("pair_first", 32'(grant), 32'b0001);
    @(posedge clk); #1; req_valid[0] = 1'b0; req_last[0] = 1'b0;
    @(negedge clk); check("pair_gap", 32'(grant), 32'd0);
    @(negedge clk); check("pair_second", 32'(grant), 32'b0100);
    @(posedge clk); #1; req_valid = '0; req_last = '0;
    @(posedge clk); #1;
    arb_round(4'b1001, 4'b1000);

    // 20-byte stream split by the burst cap
    runs_q.delete();
    send_pkt(1, 20, 8'h80, 1'b1);
    @(posedge clk); #1;
    r0 = (runs_q.size() > 0) ? runs_q[0] : -1;
    r1 = (runs_q.size() > 1) ? runs_q[1] : -1;
    check("burst_runs", 32'(runs_q.size()), 32'd2);
    check("burst_first_run", 32'(r0), 32'd16);
    check("burst_second_run", 32'(r1), 32'd4);

    // req3 goes idle after one byte; req0 waits for the timeout
    xfer_byte(3, 8'hC3, 1'b0, w);
    check("to_owner_latency", 32'(w), 32'd1);
    req_valid[3] = 1'b0;
    req_valid[0] = 1'b1; req_data[0*W +: W] = 8'h0E; req_last[0] = 1'b1;
    sb_q.push_back('{src: 2'd0, data: 8'h0E});
    cnt = 0;
    forever begin
      @(negedge clk);
      if (grant != 4'b1000 || cnt > 300) break;
      cnt++;
    end
    check("to_idle_cycles", 32'(cnt), 32'd64);
    check("to_released", 32'(grant), 32'd0);
    @(negedge clk); check("to_next_owner", 32'(grant), 32'b0001);
    @(posedge clk); #1; req_valid = '0; req_last = '0;
    @(posedge clk); #1;

    // backpressure: no beat, no timeout, stable data
    tx_ready = 1'b0;
    req_valid[2] = 1'b1; req_data[2*W +: W] = 8'hA5; req_last[2] = 1'b1;
    sb_q.push_back('{src: 2'd2, data: 8'hA5});
    b0 = n_beats;
    @(negedge clk);
    stable = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (grant !== 4'b0100 || tx_dout !== 8'hA5 || tx_valid !== 1'b1 || req_ready !== 4'b0000)
        stable = 1'b0;
    end
    check("bp_held_stable", 32'(stable), 32'd1);
    check("bp_no_beat", 32'(n_beats - b0), 32'd0);
    @(posedge clk); #1; tx_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; req_valid = '0; req_last = '0;
    repeat (3) @(posedge clk); #1;
    check("bp_one_beat", 32'(n_beats - b0), 32'd1);
    check("bp_released", 32'(busy), 32'd0);

    // reset in the middle of a burst
    xfer_byte(1, 8'h60, 1'b0, w);
    xfer_byte(1, 8'h61, 1'b0, w);
    xfer_byte(1, 8'h62, 1'b0, w);
    req_data[1*W +: W] = 8'h63;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    req_valid = '0; req_last = '0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    arb_round(4'b1110, 4'b0010);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
